// File: rtl/regfile_pkg.sv
// regfile_pkg: default geometry shared by the register file slice.
package regfile_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read/write/claim bus between datapath controller and register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  localparam int NREGS = nregs(ADDR_W);
  logic              write;
  logic [ADDR_W-1:0] writenum;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] readnum_a;
  logic [DATA_W-1:0] data_out_a;
  logic              busy_a;
  logic [ADDR_W-1:0] readnum_b;
  logic [DATA_W-1:0] data_out_b;
  logic              busy_b;
  logic              claim;
  logic [ADDR_W-1:0] claimnum;
  logic              claim_ok;
  logic [NREGS-1:0]  busy_vec;
  modport master (
    output write, writenum, data_in, readnum_a, readnum_b, claim, claimnum,
    input  data_out_a, busy_a, data_out_b, busy_b, claim_ok, busy_vec
  );
  modport slave (
    input  write, writenum, data_in, readnum_a, readnum_b, claim, claimnum,
    output data_out_a, busy_a, data_out_b, busy_b, claim_ok, busy_vec
  );
endinterface

// File: rtl/regfile_sb_register_rn.sv
// register_rn: enable register with asynchronous active-low clear.
module register_rn
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: dual-read, single-write register file with per-register busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         reset_n,
  regfile_sb_if.slave bus
);
  localparam int NREGS = nregs(ADDR_W);
  logic [DATA_W-1:0] r [NREGS];
  logic [NREGS-1:0]  busy, wr_dec, cl_dec;
  logic              hit_a, hit_b, hit_c;
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    assign wr_dec[i] = bus.write && bus.writenum == ADDR_W'(i);
    assign cl_dec[i] = bus.claim_ok && bus.claimnum == ADDR_W'(i);
    register_rn #(.DATA_W(DATA_W)) u_r (
      .clk(clk), .reset_n(reset_n), .en(wr_dec[i]), .d(bus.data_in), .q(r[i])
    );
  end
  // A claim landing with a release on the same register leaves it busy: new owner wins.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) busy <= '0;
    else busy <= (busy & ~wr_dec) | cl_dec;
  always_comb begin
    hit_a = BYPASS != 0 && bus.write && bus.writenum == bus.readnum_a;
    hit_b = BYPASS != 0 && bus.write && bus.writenum == bus.readnum_b;
    hit_c = bus.write && bus.writenum == bus.claimnum;
    bus.data_out_a = !reset_n ? '0 : hit_a ? bus.data_in : r[bus.readnum_a];
    bus.data_out_b = !reset_n ? '0 : hit_b ? bus.data_in : r[bus.readnum_b];
    bus.busy_a = reset_n && !hit_a && busy[bus.readnum_a];
    bus.busy_b = reset_n && !hit_b && busy[bus.readnum_b];
    bus.claim_ok = reset_n && bus.claim && (!busy[bus.claimnum] || hit_c);
    bus.busy_vec = busy;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector bench for regfile_sb (bypass, no-bypass and wide instances).
module tb_regfile_sb;
  logic clk = 0;
  logic reset_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) b1 ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) b0 ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bw ();
  regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  regfile_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(1)) uw (.clk(clk), .reset_n(reset_n), .bus(bw));

  typedef struct {
    logic        wr;
    logic [2:0]  wn;
    logic [15:0] din;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        cl;
    logic [2:0]  cn;
    logic [15:0] da;
    logic [15:0] db;
    logic        ba;
    logic        bb;
    logic        cok;
    logic [7:0]  bv;
  } vec_t;
  vec_t tv [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          wr    wn    din       ra    rb    cl    cn    da        db        ba    bb    cok   bv
    tv[0]  = '{1'b1, 3'd1, 16'h00AA, 3'd1, 3'd6, 1'b0, 3'd0, 16'h00AA, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b1, 3'd6, 16'hBEEF, 3'd1, 3'd6, 1'b0, 3'd0, 16'h00AA, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[2]  = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd6, 1'b0, 3'd0, 16'h00AA, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[3]  = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, 1'b0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[4]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd6, 1'b1, 3'd5, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b1, 8'h00};
    tv[5]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd6, 1'b1, 3'd5, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b0, 8'h20};
    tv[6]  = '{1'b1, 3'd5, 16'h0007, 3'd5, 3'd5, 1'b0, 3'd0, 16'h0007, 16'h0007, 1'b0, 1'b0, 1'b0, 8'h20};
    tv[7]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd6, 1'b1, 3'd4, 16'h0007, 16'hBEEF, 1'b0, 1'b0, 1'b1, 8'h00};
    tv[8]  = '{1'b1, 3'd4, 16'h1111, 3'd4, 3'd6, 1'b1, 3'd4, 16'h1111, 16'hBEEF, 1'b0, 1'b0, 1'b1, 8'h10};
    tv[9]  = '{1'b1, 3'd0, 16'h2222, 3'd4, 3'd7, 1'b1, 3'd7, 16'h1111, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h10};
    tv[10] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b1, 3'd7, 16'h2222, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h90};
    tv[11] = '{1'b1, 3'd7, 16'h3333, 3'd7, 3'd4, 1'b1, 3'd7, 16'h3333, 16'h1111, 1'b0, 1'b1, 1'b1, 8'h90};
    tv[12] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd4, 1'b0, 3'd0, 16'h3333, 16'h1111, 1'b1, 1'b1, 1'b0, 8'h90};

    {b0.write, b0.writenum, b0.data_in, b0.readnum_a, b0.readnum_b, b0.claim, b0.claimnum} = '0;
    {bw.write, bw.writenum, bw.data_in, bw.readnum_a, bw.readnum_b, bw.claim, bw.claimnum} = '0;
    // In reset a forwarded write and a claim must still read as zero.
    b1.write = 1; b1.writenum = 3'd2; b1.data_in = 16'hFFFF; b1.readnum_a = 3'd2; b1.readnum_b = 3'd2;
    b1.claim = 1; b1.claimnum = 3'd2;
    #2;
    chk("rst data_a", 32'(b1.data_out_a), 32'h0);
    chk("rst busy_a", 32'(b1.busy_a), 32'h0);
    chk("rst claim_ok", 32'(b1.claim_ok), 32'h0);
    chk("rst busy_vec", 32'(b1.busy_vec), 32'h0);
    b1.write = 0; b1.claim = 0;
    step();
    reset_n = 1;
    step();

    for (int i = 0; i < 13; i++) begin
      b1.write = tv[i].wr; b1.writenum = tv[i].wn; b1.data_in = tv[i].din;
      b1.readnum_a = tv[i].ra; b1.readnum_b = tv[i].rb;
      b1.claim = tv[i].cl; b1.claimnum = tv[i].cn;
      #1;
      chk($sformatf("v%0d data_a", i), 32'(b1.data_out_a), 32'(tv[i].da));
      chk($sformatf("v%0d data_b", i), 32'(b1.data_out_b), 32'(tv[i].db));
      chk($sformatf("v%0d busy_a", i), 32'(b1.busy_a), 32'(tv[i].ba));
      chk($sformatf("v%0d busy_b", i), 32'(b1.busy_b), 32'(tv[i].bb));
      chk($sformatf("v%0d claim_ok", i), 32'(b1.claim_ok), 32'(tv[i].cok));
      chk($sformatf("v%0d busy_vec", i), 32'(b1.busy_vec), 32'(tv[i].bv));
      step();
    end
    b1.write = 0; b1.claim = 0;

    // BYPASS=0: write data and busy release appear only after the edge.
    b0.claim = 1; b0.claimnum = 3'd3;
    step();
    b0.claim = 0; b0.write = 1; b0.writenum = 3'd2; b0.data_in = 16'h5A5A;
    b0.readnum_a = 3'd2; b0.readnum_b = 3'd3;
    #1;
    chk("nb data_a pre", 32'(b0.data_out_a), 32'h0);
    chk("nb busy_b claimed", 32'(b0.busy_b), 32'h1);
    step();
    b0.writenum = 3'd3; b0.data_in = 16'h0042;
    #1;
    chk("nb data_a post", 32'(b0.data_out_a), 32'h5A5A);
    chk("nb busy_b pre", 32'(b0.busy_b), 32'h1);
    chk("nb data_b pre", 32'(b0.data_out_b), 32'h0);
    step();
    b0.write = 0;
    #1;
    chk("nb busy_b post", 32'(b0.busy_b), 32'h0);
    chk("nb data_b post", 32'(b0.data_out_b), 32'h0042);
    chk("nb busy_vec", 32'(b0.busy_vec), 32'h0);

    // 32-bit, 16-deep instance.
    bw.write = 1; bw.writenum = 4'd15; bw.data_in = 32'hDEADBEEF; bw.readnum_a = 4'd15;
    #1;
    chk("w data_a bypass", bw.data_out_a, 32'hDEADBEEF);
    step();
    bw.write = 0; bw.readnum_b = 4'd15; bw.claim = 1; bw.claimnum = 4'd15;
    #1;
    chk("w data_b", bw.data_out_b, 32'hDEADBEEF);
    chk("w claim_ok", 32'(bw.claim_ok), 32'h1);
    step();
    bw.claim = 0;
    #1;
    chk("w busy_vec", 32'(bw.busy_vec), 32'h8000);
    chk("w busy_b", 32'(bw.busy_b), 32'h1);

    // Mid-run reset between edges.
    b1.write = 1; b1.writenum = 3'd3; b1.data_in = 16'h1234;
    step();
    b1.write = 0; b1.readnum_a = 3'd3;
    #1;
    chk("mr data_a pre", 32'(b1.data_out_a), 32'h1234);
    chk("mr busy_vec pre", 32'(b1.busy_vec), 32'h90);
    b1.claim = 1; b1.claimnum = 3'd1;
    #2;
    reset_n = 0;
    #1;
    chk("mr data_a in reset", 32'(b1.data_out_a), 32'h0);
    chk("mr busy_vec in reset", 32'(b1.busy_vec), 32'h0);
    chk("mr claim_ok in reset", 32'(b1.claim_ok), 32'h0);
    chk("mr wide busy_vec in reset", 32'(bw.busy_vec), 32'h0);
    b1.claim = 0;
    #2;
    reset_n = 1;
    step();
    chk("mr data_a after", 32'(b1.data_out_a), 32'h0);
    chk("mr busy_vec after", 32'(b1.busy_vec), 32'h0);
    b1.readnum_a = 3'd6;
    #1;
    chk("mr r6 after", 32'(b1.data_out_a), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the 8x16 single-port register file for the Simple RISC Machine datapath.
- Width and depth generalised.
- Two independent combinational read ports (A/B), so the datapath reads Rn and Rm in one cycle.
- One synchronous write port with optional write-to-read bypass.
- Per-register busy scoreboard: the controller claims a destination register when issuing and the write releases it, so read-after-write hazards are detectable.

Parameters:
DATA_W, 16, register width in bits.
ADDR_W, 3, register-number width; depth NREGS = 2**ADDR_W.
BYPASS, 1, 1 = same-cycle write data/busy-release forwarded to read ports; 0 = reads see registered state only.

Ports:
clk  in  1  rising-edge clock.
reset_n  in  1  asynchronous active-low reset.
write  in  1  write enable.
writenum  in  ADDR_W  destination register of write.
data_in  in  DATA_W  write data.
readnum_a  in  ADDR_W  read port A select.
data_out_a  out  DATA_W  read port A data.
busy_a  out  1  register readnum_a has a pending claim.
readnum_b  in  ADDR_W  read port B select.
data_out_b  out  DATA_W  read port B data.
busy_b  out  1  register readnum_b has a pending claim.
claim  in  1  request to mark claimnum busy.
claimnum  in  ADDR_W  register to claim.
claim_ok  out  1  claim accepted this cycle.
busy_vec  out  NREGS  full scoreboard state (debug/status).

Behaviour:
Reset:
- reset_n low asynchronously clears all registers to 0 and all busy bits to 0.
- While reset_n is low: data_out_a/b = 0, busy_a/b = 0, busy_vec = 0, claim_ok = 0.
- Release is sampled on the next rising clk. A write or claim in flight at reset assertion is lost.

Write:
- At posedge, if write=1: R[writenum] <= data_in and busy[writenum] <= 0, unless cleared-and-reclaimed (see Claim).
- Write to a register with busy=0 is legal; data updates and busy stays 0.

Read:
- Purely combinational, zero latency.
- data_out_x = R[readnum_x], except when BYPASS=1 and write=1 and writenum==readnum_x, in which case data_out_x = data_in.
- Both ports may select the same register or the write target simultaneously; each resolves independently.

Busy outputs:
- busy_x = busy[readnum_x], except when BYPASS=1 and write=1 and writenum==readnum_x, in which case busy_x = 0 (release forwarded).
- BYPASS=0: busy_x shows registered state only; release is visible one cycle after the write.

Claim:
- claim_ok = claim & (~busy[claimnum] | (write & writenum==claimnum)), combinational, independent of BYPASS.
- At posedge, if claim_ok: busy[claimnum] <= 1.
- Simultaneous write and claim on the same register: data is written and busy ends at 1 (new owner wins over release).
- Claim on a busy register with no matching write: claim_ok=0, state unchanged; the controller must retry (stall).
- Write and claim on different registers: both take effect in the same cycle.

Other rules:
- No arithmetic; all indices are full-range, so there is no out-of-range case.
- busy_vec is the registered busy bits, bit i = register i.

Decomposition:
- Shared package regfile_pkg: default DATA_W/ADDR_W constants and a function computing NREGS from ADDR_W.
- One natural sub-module: register_rn, a DATA_W enable register with asynchronous active-low clear, instantiated NREGS times.
- Write decode, read muxes and the scoreboard stay in the top module.

Test Plan:
- Reset mid-run: write R3=16'h1234, assert reset_n=0 between edges -> data_out_a (readnum_a=3) = 0 immediately, busy_vec = 0; after release, R3 reads 0.
- Dual read: write R1=16'h00AA, R6=16'hBEEF over two cycles; readnum_a=1, readnum_b=6 -> 16'h00AA / 16'hBEEF same cycle; both ports on 6 -> both 16'hBEEF.
- Bypass: BYPASS=1, write=1, writenum=2, data_in=16'h5A5A, readnum_a=2, old R2=0 -> data_out_a=16'h5A5A before the edge. Same stimulus with BYPASS=0 -> 0 before the edge, 16'h5A5A after.
- Scoreboard lifecycle: claim R5 -> claim_ok=1, next cycle busy_vec[5]=1 and busy_a=1 (readnum_a=5). Second claim R5 -> claim_ok=0. Write R5=16'h0007 -> busy_a=0 during that cycle (BYPASS=1), busy_vec[5]=0 after.
- Simultaneous write+claim on R4 (busy) -> claim_ok=1, R4 = data_in, busy_vec[4] remains 1. Write R0 + claim R7 -> R0 updated, busy_vec[7]=1.
- Parametrisation: DATA_W=32, ADDR_W=4 -> write/read R15 = 32'hDEADBEEF, claim R15 sets busy_vec[15].
